// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the NPC core.
// Services one CSR/ECALL/MRET/IRQ command per valid/ready transaction (IDLE->EXEC->RESP).
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] HARTID      = '0,
    parameter logic [63:0]     MSTATUS_RST = 64'h0000000a00001800,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      cmd_i,
    input  logic [2:0]      func3_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o,
    input  logic            timer_irq_i,
    output logic            irq_pending_o
);

    localparam logic [1:0] CMD_CSR   = 2'b00;
    localparam logic [1:0] CMD_ECALL = 2'b01;
    localparam logic [1:0] CMD_MRET  = 2'b10;
    localparam logic [1:0] CMD_IRQ   = 2'b11;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    // mstatus bits other than MIE/MPIE are frozen; MPP is hard-wired to M-mode
    localparam logic [XLEN-1:0] MSTATUS_FIXED =
        (XLEN'(MSTATUS_RST) & ~XLEN'(64'h88)) | XLEN'(64'h1800);
    localparam logic [XLEN-1:0] MTVEC_MASK  = ~XLEN'(2);
    localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);
    localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
    localparam logic [XLEN-1:0] TIMER_VEC   = XLEN'(28);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q;
    logic [1:0]        cmd_q;
    logic [2:0]        func3_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   pc_q;

    logic              mst_mie_q;
    logic              mst_mpie_q;
    logic              mie_mtie_q;
    logic [XLEN-1:0]   mtvec_q;
    logic [XLEN-1:0]   mscratch_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [XLEN-1:0]   mcycle_q;

    logic [XLEN-1:0]   mstatus_rd;
    logic [XLEN-1:0]   mie_rd;
    logic [XLEN-1:0]   mip_rd;
    logic [XLEN-1:0]   trap_base;
    logic [XLEN-1:0]   csr_old;
    logic [XLEN-1:0]   csr_new;
    logic [1:0]        op;
    logic              csr_hit;
    logic              csr_ro;
    logic              csr_writes;
    logic              csr_illegal;

    // Immediate vs register forms differ only in how wdata_i was formed upstream
    logic unused_func3;
    assign unused_func3 = func3_q[2];

    always_comb begin
        mstatus_rd    = MSTATUS_FIXED;
        mstatus_rd[3] = mst_mie_q;
        mstatus_rd[7] = mst_mpie_q;
        mie_rd        = '0;
        mie_rd[7]     = mie_mtie_q;
        mip_rd        = '0;
        mip_rd[7]     = timer_irq_i;
        trap_base     = {mtvec_q[XLEN-1:2], 2'b00};
    end

    // CSR read mux, new-value computation and legality
    always_comb begin
        op      = func3_q[1:0];
        csr_hit = 1'b1;
        csr_ro  = 1'b0;
        csr_old = '0;
        case (addr_q)
            A_MSTATUS:  csr_old = mstatus_rd;
            A_MIE:      csr_old = mie_rd;
            A_MTVEC:    csr_old = mtvec_q;
            A_MSCRATCH: csr_old = mscratch_q;
            A_MEPC:     csr_old = mepc_q;
            A_MCAUSE:   csr_old = mcause_q;
            A_MIP: begin
                csr_old = mip_rd;
                csr_ro  = 1'b1;
            end
            A_MCYCLE:   csr_old = mcycle_q;
            A_MHARTID: begin
                csr_old = HARTID;
                csr_ro  = 1'b1;
            end
            default:    csr_hit = 1'b0;
        endcase

        case (op)
            OP_RW:   csr_new = wdata_q;
            OP_RS:   csr_new = csr_old | wdata_q;
            OP_RC:   csr_new = csr_old & ~wdata_q;
            default: csr_new = csr_old;
        endcase

        // set/clear with a zero operand is a pure read
        csr_writes  = (op == OP_RW) || ((op != OP_NONE) && (wdata_q != '0));
        csr_illegal = (op == OP_NONE) || !csr_hit || (csr_ro && csr_writes);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_CSR;
            func3_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            mst_mie_q     <= MSTATUS_RST[3];
            mst_mpie_q    <= MSTATUS_RST[7];
            mie_mtie_q    <= 1'b0;
            mtvec_q       <= MTVEC_RST & MTVEC_MASK;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mcycle_q      <= '0;
            ready_o       <= 1'b0;
            rdata_o       <= '0;
            redirect_o    <= 1'b0;
            pc_o          <= '0;
            illegal_o     <= 1'b0;
            irq_pending_o <= 1'b0;
        end else begin
            mcycle_q      <= mcycle_q + XLEN'(1);
            irq_pending_o <= mst_mie_q & mie_mtie_q & timer_irq_i;
            ready_o       <= 1'b0;
            rdata_o       <= '0;
            redirect_o    <= 1'b0;
            pc_o          <= '0;
            illegal_o     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        cmd_q   <= cmd_i;
                        func3_q <= func3_i;
                        addr_q  <= csr_addr_i;
                        wdata_q <= wdata_i;
                        pc_q    <= pc_i;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_RESP;
                    ready_o <= 1'b1;
                    case (cmd_q)
                        CMD_CSR: begin
                            if (csr_illegal) begin
                                illegal_o <= 1'b1;
                            end else begin
                                rdata_o <= csr_old;
                                if (csr_writes) begin
                                    case (addr_q)
                                        A_MSTATUS: begin
                                            mst_mie_q  <= csr_new[3];
                                            mst_mpie_q <= csr_new[7];
                                        end
                                        A_MIE:      mie_mtie_q <= csr_new[7];
                                        A_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
                                        A_MSCRATCH: mscratch_q <= csr_new;
                                        A_MEPC:     mepc_q     <= {csr_new[XLEN-1:2], 2'b00};
                                        A_MCAUSE:   mcause_q   <= csr_new;
                                        A_MCYCLE:   mcycle_q   <= csr_new;
                                        default: ;
                                    endcase
                                end
                            end
                        end
                        CMD_ECALL: begin
                            mepc_q     <= {pc_q[XLEN-1:2], 2'b00};
                            mcause_q   <= ECALL_CAUSE;
                            mst_mpie_q <= mst_mie_q;
                            mst_mie_q  <= 1'b0;
                            redirect_o <= 1'b1;
                            pc_o       <= trap_base;
                        end
                        CMD_MRET: begin
                            mst_mie_q  <= mst_mpie_q;
                            mst_mpie_q <= 1'b1;
                            redirect_o <= 1'b1;
                            pc_o       <= mepc_q;
                        end
                        CMD_IRQ: begin
                            mepc_q     <= {pc_q[XLEN-1:2], 2'b00};
                            mcause_q   <= IRQ_CAUSE;
                            mst_mpie_q <= mst_mie_q;
                            mst_mie_q  <= 1'b0;
                            redirect_o <= 1'b1;
                            pc_o       <= trap_base + (mtvec_q[0] ? TIMER_VEC : '0);
                        end
                        default: ;
                    endcase
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: directed scenarios then random commands
// checked against an architectural model of the machine-mode CSRs.
module tb_csr_trap_unit;

    localparam logic [63:0] HART = 64'h5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  cmd_i = 2'b00;
    logic [2:0]  func3_i = 3'b000;
    logic [11:0] csr_addr_i = 12'h000;
    logic [63:0] wdata_i = 64'h0;
    logic [63:0] pc_i = 64'h0;
    logic [63:0] rdata_o;
    logic        redirect_o;
    logic [63:0] pc_o;
    logic        illegal_o;
    logic        timer_irq_i = 1'b0;
    logic        irq_pending_o;

    csr_trap_unit #(.XLEN(64), .HARTID(HART)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .cmd_i(cmd_i), .func3_i(func3_i), .csr_addr_i(csr_addr_i),
        .wdata_i(wdata_i), .pc_i(pc_i), .rdata_o(rdata_o),
        .redirect_o(redirect_o), .pc_o(pc_o), .illegal_o(illegal_o),
        .timer_irq_i(timer_irq_i), .irq_pending_o(irq_pending_o)
    );

    always #5 clk = ~clk;

    longint edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        longint      edge_n;
        logic [63:0] rdata;
        logic        redirect;
        logic [63:0] pc;
        logic        illegal;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   tx_id = 0;
    bit   mon_en = 1'b0;

    // architectural state of the model
    bit          m_mie, m_mpie, m_mtie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] mc_base_val;
    longint      mc_base_edge;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endfunction

    function automatic logic [63:0] m_mstatus();
        return 64'ha00001800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
    endfunction

    // expected response of one command executing at edge ex; updates the model
    task automatic model_step(input logic [1:0] cmd, input logic [2:0] f3, input logic [11:0] a,
                              input logic [63:0] w, input logic [63:0] pc, input logic tmr,
                              input longint ex, output exp_t e);
        logic [63:0] old, nv, base;
        bit impl, ro, wr;
        logic [1:0] op;
        e.edge_n = ex; e.rdata = 0; e.redirect = 0; e.pc = 0; e.illegal = 0; e.id = tx_id;
        tx_id++;
        base = m_mtvec & ~64'h3;
        case (cmd)
            2'b00: begin
                op = f3[1:0]; impl = 1; ro = 0; old = 0;
                case (a)
                    12'h300: old = m_mstatus();
                    12'h304: old = 64'(m_mtie) << 7;
                    12'h305: old = m_mtvec;
                    12'h340: old = m_mscratch;
                    12'h341: old = m_mepc;
                    12'h342: old = m_mcause;
                    12'h344: begin old = 64'(tmr) << 7; ro = 1; end
                    12'hB00: old = mc_base_val + 64'(ex - mc_base_edge - 1);
                    12'hF14: begin old = HART; ro = 1; end
                    default: impl = 0;
                endcase
                wr = (op == 2'b01) || (op != 2'b00 && w != 0);
                if (op == 2'b00 || !impl || (ro && wr)) e.illegal = 1;
                else begin
                    e.rdata = old;
                    if (wr) begin
                        nv = (op == 2'b01) ? w : (op == 2'b10) ? (old | w) : (old & ~w);
                        case (a)
                            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                            12'h304: m_mtie = nv[7];
                            12'h305: m_mtvec = nv & ~64'h2;
                            12'h340: m_mscratch = nv;
                            12'h341: m_mepc = nv & ~64'h3;
                            12'h342: m_mcause = nv;
                            12'hB00: begin mc_base_val = nv; mc_base_edge = ex; end
                            default: ;
                        endcase
                    end
                end
            end
            2'b01: begin
                m_mepc = pc & ~64'h3; m_mcause = 64'd11;
                m_mpie = m_mie; m_mie = 0;
                e.redirect = 1; e.pc = base;
            end
            2'b10: begin
                e.redirect = 1; e.pc = m_mepc;
                m_mie = m_mpie; m_mpie = 1;
            end
            default: begin
                m_mepc = pc & ~64'h3; m_mcause = 64'h8000_0000_0000_0007;
                m_mpie = m_mie; m_mie = 0;
                e.redirect = 1; e.pc = base + (m_mtvec[0] ? 64'd28 : 64'd0);
            end
        endcase
    endtask

    // monitor: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ready_o) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ready actual=1 expected=0");
                end else begin
                    mon_e = sb_q.pop_front();
                    check($sformatf("tx%0d_latency", mon_e.id), 64'(edge_cnt), 64'(mon_e.edge_n));
                    check($sformatf("tx%0d_rdata", mon_e.id), rdata_o, mon_e.rdata);
                    check($sformatf("tx%0d_redirect", mon_e.id), 64'(redirect_o), 64'(mon_e.redirect));
                    check($sformatf("tx%0d_pc", mon_e.id), pc_o, mon_e.pc);
                    check($sformatf("tx%0d_illegal", mon_e.id), 64'(illegal_o), 64'(mon_e.illegal));
                end
            end else begin
                check("idle_outputs_zero", rdata_o | pc_o | 64'({redirect_o, illegal_o}), 64'h0);
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1; valid_i = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 0;
        mc_base_edge = edge_cnt; mc_base_val = 0;
        m_mie = 0; m_mpie = 0; m_mtie = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        sb_q.delete();
        @(negedge clk);
    endtask

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic issue(input logic [1:0] cmd, input logic [2:0] f3, input logic [11:0] a,
                         input logic [63:0] w, input logic [63:0] pc, input bit early);
        exp_t e;
        bit seen;
        model_step(cmd, f3, a, w, pc, timer_irq_i, edge_cnt + 2, e);
        sb_q.push_back(e);
        cmd_i = cmd; func3_i = f3; csr_addr_i = a; wdata_i = w; pc_i = pc; valid_i = 1;
        if (early) begin
            @(posedge clk);
            #1 valid_i = 0;
            cmd_i = 2'($urandom); csr_addr_i = 12'($urandom);
            wdata_i = {$urandom, $urandom}; pc_i = {$urandom, $urandom};
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_o) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL tx%0d_timeout actual=no_ready expected=ready", e.id);
            sb_q.delete();
        end
        valid_i = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pend(input string name);
        @(negedge clk);
        check(name, 64'(irq_pending_o), 64'(m_mie & m_mtie & timer_irq_i));
    endtask

    initial begin
        logic [11:0] addrs [0:11];
        logic [11:0] a;
        logic [63:0] w;
        int r;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h344, 12'hB00, 12'hF14, 12'h7C0, 12'h301, 12'h000};

        do_reset(3);
        mon_en = 1;
        check("rst_ready", 64'(ready_o), 64'h0);
        check("rst_outputs", rdata_o | pc_o | 64'({redirect_o, illegal_o}), 64'h0);
        check("rst_irq_pending", 64'(irq_pending_o), 64'h0);

        // reset values and a pure read
        issue(2'b00, 3'b010, 12'h300, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h305, 64'h0, 64'h0, 0);

        // vectored mtvec, ECALL takes the direct base
        issue(2'b00, 3'b001, 12'h305, 64'h80001003, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h305, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b001, 12'h305, 64'h80001001, 64'h0, 0);
        issue(2'b01, 3'b000, 12'h000, 64'h0, 64'h80000100, 0);
        issue(2'b00, 3'b010, 12'h341, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h342, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h300, 64'h0, 64'h0, 0);

        // timer interrupt entry and return
        issue(2'b00, 3'b110, 12'h300, 64'h8, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h304, 64'h80, 64'h0, 0);
        check_pend("pend_timer_low");
        timer_irq_i = 1;
        check_pend("pend_timer_high");
        issue(2'b00, 3'b010, 12'h344, 64'h0, 64'h0, 0);
        issue(2'b11, 3'b000, 12'h000, 64'h0, 64'h80000200, 0);
        check_pend("pend_after_irq");
        issue(2'b00, 3'b010, 12'h342, 64'h0, 64'h0, 0);
        issue(2'b10, 3'b000, 12'h000, 64'h0, 64'h0, 0);
        check_pend("pend_after_mret");
        issue(2'b00, 3'b010, 12'h300, 64'h0, 64'h0, 0);
        timer_irq_i = 0;
        check_pend("pend_timer_dropped");

        // set/clear, read-only and unimplemented accesses
        issue(2'b00, 3'b001, 12'h340, 64'hFF, 64'h0, 0);
        issue(2'b00, 3'b011, 12'h340, 64'h0F, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h340, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b001, 12'hF14, 64'h77, 64'h0, 0);
        issue(2'b00, 3'b010, 12'hF14, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h7C0, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b000, 12'h340, 64'h1, 64'h0, 0);
        issue(2'b00, 3'b111, 12'h344, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b101, 12'h344, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b101, 12'h341, 64'h1F, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h341, 64'h0, 64'h0, 0);

        // mcycle wraps; the write itself suppresses that cycle's increment
        issue(2'b00, 3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 0);
        @(negedge clk);
        issue(2'b00, 3'b010, 12'hB00, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'hB00, 64'h0, 64'h0, 0);

        // reset during EXEC of an mscratch write aborts it
        issue(2'b00, 3'b001, 12'h340, 64'h1234, 64'h0, 0);
        cmd_i = 2'b00; func3_i = 3'b001; csr_addr_i = 12'h340; wdata_i = 64'hDEAD; valid_i = 1;
        @(posedge clk);
        @(negedge clk);
        do_reset(2);
        check("abort_ready", 64'(ready_o), 64'h0);
        check("abort_outputs", rdata_o | pc_o | 64'({redirect_o, illegal_o}), 64'h0);
        issue(2'b00, 3'b010, 12'h340, 64'h0, 64'h0, 0);
        issue(2'b00, 3'b010, 12'h300, 64'h0, 64'h0, 0);

        // request withdrawn right after acceptance still completes
        issue(2'b00, 3'b001, 12'h342, 64'hCAFE, 64'h0, 1);
        issue(2'b00, 3'b010, 12'h342, 64'h0, 64'h0, 0);

        for (int n = 0; n < 250; n++) begin
            timer_irq_i = 1'($urandom_range(0, 1));
            check_pend($sformatf("rnd%0d_pending", n));
            r = $urandom_range(0, 11);
            a = (r == 11) ? 12'($urandom) : addrs[r];
            r = $urandom_range(0, 9);
            w = (r < 3) ? 64'h0 : (r < 5) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            r = $urandom_range(0, 19);
            issue((r < 12) ? 2'b00 : 2'($urandom_range(1, 3)), 3'($urandom), a, w,
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
